// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the register-sharing arbiter family.
//   state_e : FSM state encoding (idle / grant)
//   clog2   : index width helper, never returns less than 1
package reg_share_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   // Width of an index able to address n items; at least one bit so that
   // index ports stay legal for n = 1 or 2.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req : per-requester request vector
//   ptr : index that has highest priority this round
//   sel : first set req bit found searching ptr, ptr+1, ... (mod N)
//   any : at least one request is set (sel is only meaningful when high)
module reg_share_arbiter_rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] sel,
   output logic          any
);

   always_comb begin
      int unsigned idx;
      logic        found;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter in front of one shared W-bit register.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   req     : per-requester level request, held until ack
//   d_in    : packed write data, requester i on d_in[i*W +: W]
//   gnt     : registered one-hot grant
//   ack     : one-cycle one-hot pulse, write committed
//   q       : shared register contents
//   owner   : index of the last requester that committed
//   busy    : high while a grant is outstanding
module reg_share_arbiter
   import reg_share_arbiter_pkg::*;
#(
   parameter int unsigned   N         = 4,
   parameter int unsigned   W         = 4,
   parameter logic [W-1:0]  RESET_VAL = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [N-1:0]          req,
   input  logic [N*W-1:0]        d_in,
   output logic [N-1:0]          gnt,
   output logic [N-1:0]          ack,
   output logic [W-1:0]          q,
   output logic [clog2(N)-1:0]   owner,
   output logic                  busy
);

   localparam int unsigned PW = clog2(N);

   state_e        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] sel_q, sel_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [N-1:0]  ack_q, ack_d;
   logic [W-1:0]  q_q, q_d;
   logic [PW-1:0] owner_q, owner_d;
   logic          busy_q, busy_d;

   logic [PW-1:0] pick_sel;
   logic          pick_any;

   reg_share_arbiter_rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_rr_pick (
      .req (req),
      .ptr (ptr_q),
      .sel (pick_sel),
      .any (pick_any)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      gnt_d   = '0;
      ack_d   = '0;
      q_d     = q_q;
      owner_d = owner_q;
      busy_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               gnt_d   = N'(1) << pick_sel;
               sel_d   = pick_sel;
               busy_d  = 1'b1;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            state_d = ST_IDLE;
            // A withdrawn request aborts silently: nothing but the grant changes.
            if (req[sel_q]) begin
               q_d     = d_in[int'(sel_q)*W +: W];
               ack_d   = N'(1) << sel_q;
               owner_d = sel_q;
               ptr_d   = (int'(sel_q) == int'(N) - 1) ? '0 : sel_q + PW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         q_q     <= RESET_VAL;
         owner_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         q_q     <= q_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt   = gnt_q;
   assign ack   = ack_q;
   assign q     = q_q;
   assign owner = owner_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter with a commit scoreboard.
module tb_reg_share_arbiter;

   localparam int N = 4;
   localparam int W = 4;

   logic           clk;
   logic           reset_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] d_in;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic [W-1:0]   q;
   logic [1:0]     owner;
   logic           busy;

   int vectors;
   int miscompares;

   typedef struct {
      logic [N-1:0] ack;
      logic [W-1:0] q;
      logic [1:0]   owner;
   } exp_t;

   exp_t sb[$];

   reg_share_arbiter #(
      .N         (N),
      .W         (W),
      .RESET_VAL (4'b0000)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .d_in    (d_in),
      .gnt     (gnt),
      .ack     (ack),
      .q       (q),
      .owner   (owner),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int idx, input logic [W-1:0] data);
      exp_t e;
      e.ack   = N'(1) << idx;
      e.q     = data;
      e.owner = 2'(idx);
      sb.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_q"},     32'(q),     32'h0);
      check({tag, "_gnt"},   32'(gnt),   32'h0);
      check({tag, "_ack"},   32'(ack),   32'h0);
      check({tag, "_owner"}, 32'(owner), 32'h0);
      check({tag, "_busy"},  32'(busy),  32'h0);
   endtask

   // Runs cycles until n commits are seen; each requester drops req on its ack.
   task automatic run_commits(input int n, input int budget);
      int           got;
      int           last;
      logic [N-1:0] prev_gnt;
      exp_t         e;
      got      = 0;
      last     = -1;
      prev_gnt = gnt;
      for (int c = 0; c < budget && got < n; c++) begin
         @(negedge clk);
         check("gnt_onehot0", 32'($onehot0(gnt)), 32'h1);
         if (ack !== '0) begin
            check("ack_after_gnt", 32'(ack), 32'(prev_gnt));
            if (sb.size() == 0) begin
               check("unexpected_ack", 32'(ack), 32'h0);
            end else begin
               e = sb.pop_front();
               check("commit_ack",   32'(ack),   32'(e.ack));
               check("commit_q",     32'(q),     32'(e.q));
               check("commit_owner", 32'(owner), 32'(e.owner));
               if (last >= 0) check("ack_spacing", 32'(c - last), 32'd2);
               last = c;
               req  = req & ~e.ack;
               got++;
            end
         end
         prev_gnt = gnt;
      end
      check("commit_count", 32'(got), 32'(n));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      // Reset held with all requests active.
      reset_n = 1'b0;
      req     = 4'b1111;
      d_in    = 16'hffff;
      #2;
      check_reset_outputs("reset_early");
      @(negedge clk);
      check_reset_outputs("reset_after_edge");
      req = '0;
      #2 reset_n = 1'b1;

      // Single request from requester 0.
      @(negedge clk);
      req  = 4'b0001;
      d_in = 16'h0003;
      push(0, 4'b0011);
      @(negedge clk);
      check("single_gnt",  32'(gnt),  32'h1);
      check("single_busy", 32'(busy), 32'h1);
      check("single_ack",  32'(ack),  32'h0);
      check("single_q",    32'(q),    32'h0);
      run_commits(1, 4);
      @(negedge clk);
      check("single_ack_pulse", 32'(ack),  32'h0);
      check("single_busy_idle", 32'(busy), 32'h0);
      check("single_q_hold",    32'(q),    32'h3);

      // Re-reset so the pointer starts at 0.
      reset_n = 1'b0;
      #2;
      check("rereset_q",     32'(q),     32'h0);
      check("rereset_owner", 32'(owner), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Full contention: order 0,1,2,3.
      @(negedge clk);
      req  = 4'b1111;
      d_in = 16'b1000_0100_0010_0001;
      push(0, 4'b0001);
      push(1, 4'b0010);
      push(2, 4'b0100);
      push(3, 4'b1000);
      run_commits(4, 20);

      // Wrap and fairness: pointer is back at 0 after requester 3.
      req  = 4'b1001;
      d_in = 16'b1110_0000_0000_0101;
      push(0, 4'b0101);
      push(3, 4'b1110);
      run_commits(2, 10);

      // Abort: requester 2 withdraws during its grant.
      req  = 4'b0100;
      d_in = 16'b0000_1010_0000_0000;
      @(negedge clk);
      check("abort_gnt",  32'(gnt),  32'h4);
      check("abort_busy", 32'(busy), 32'h1);
      req = '0;
      @(negedge clk);
      check("abort_ack",   32'(ack),   32'h0);
      check("abort_gnt0",  32'(gnt),   32'h0);
      check("abort_busy0", 32'(busy),  32'h0);
      check("abort_q",     32'(q),     32'he);
      check("abort_owner", 32'(owner), 32'h3);
      // Pointer still at 0: requester 0 must win over 3.
      req  = 4'b1001;
      d_in = 16'b0110_0000_0000_1001;
      push(0, 4'b1001);
      push(3, 4'b0110);
      run_commits(2, 10);

      // Asynchronous reset in the grant cycle.
      req  = 4'b0010;
      d_in = 16'b0000_0000_0111_0000;
      @(posedge clk);
      #1;
      check("arst_gnt_before", 32'(gnt), 32'h2);
      #2 reset_n = 1'b0;
      #1;
      check_reset_outputs("arst_immediate");
      @(negedge clk);
      req = '0;
      #7;
      check_reset_outputs("arst_held");
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("arst_no_ack", 32'(ack), 32'h0);
      end

      check("scoreboard_empty", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
